load_store_align: RTL and testbench
===================================

# load_store_align

Parametrised load/store alignment unit between the MIPS datapath and the synchronous data memory. It accepts one byte/halfword/word/doubleword access at a time, extracts and sign- or zero-extends sub-word load data, and performs sub-word stores as read-modify-write. Sub-word stores never overwrite unrelated byte lanes. It replaces the single-mode byte-load selector with a handshaked, multi-cycle unit that supports signed and unsigned loads and stores at every size.

## Interface
- DATA_W, 32: memory word width in bits; legal values are 32 and 64.
- ADDR_W, 32: byte-address width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W-LG  word address, where LG = log2(DATA_W/8).
- mem_wdata  out  DATA_W  full-word write data.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en with mem_we=0.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores.
- rsp_err  out  1  access was not performed.

## Operation
- Lanes are little-endian. Byte k is data[8k+7:8k].
- The byte offset is off = req_addr[LG-1:0]. mem_addr = req_addr[ADDR_W-1:LG].
- FSM states: IDLE, READ, CAPT, WRITE, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid=1, and op, size, unsigned, addr and wdata are latched.
- Load: IDLE→READ. READ drives mem_en=1, mem_we=0 →CAPT. CAPT selects the lane at off, extends it to DATA_W and registers it into rsp_rdata →RESP.
- Store with size equal to the full DATA_W: IDLE→WRITE. WRITE drives mem_en=1, mem_we=1, mem_wdata=req_wdata →RESP.
- Sub-word store: IDLE→READ→CAPT. CAPT merges the low bytes of wdata into the lanes at off and keeps every other lane from mem_rdata. →WRITE writes the merged word →RESP.
- RESP: rsp_valid=1, held until rsp_ready=1, then →IDLE. req_ready is 0 in every state except IDLE. A request cannot be accepted in the cycle a response retires.
- Illegal size: size 3 with DATA_W=32. The request goes IDLE→RESP with rsp_err=1, rsp_rdata=0 and no memory access.
- Extension: sign-extend replicates the MSB of the selected lane. A full-width load ignores req_unsigned.
- mem_en and mem_we are 0 in IDLE, CAPT and RESP.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Latency is counted from the accept edge to the first rsp_valid cycle:
  - load: 3 cycles.
  - full-width store: 2 cycles.
  - sub-word store: 4 cycles.
  - error: 1 cycle.
- Reset asserted mid-operation clears the FSM to IDLE and drops mem_en/mem_we immediately. A sub-word store reset before WRITE leaves memory untouched.
- rsp_rdata and rsp_err are stable for as long as rsp_valid=1.

## Configuration
- Macro LSA_MISALIGN_TRAP_EN.
- Defined: an access with off not a multiple of the access size in bytes (half with off[0]≠0, word with off[1:0]≠0, and so on) is an error. The unit goes IDLE→RESP with rsp_err=1 and makes no memory access.
- Undefined: misalignment is not checked. The low off bits below the access size are forced to 0, so the access is aligned down, and rsp_err is set only for an illegal size.

## Structure
- Package lsa_pkg holds:
  - size encodings: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3.
  - the FSM state enum.
  - a function returning the access byte count from the size.
- Sub-module load_extend: combinational. Inputs are the word, off, size and unsigned flag; output is the extended data. It is instantiated once, in the CAPT path.

## Test plan
- DATA_W=32, mem[0x10]=0x80FF7F01. lb at 0x12 → rsp_rdata=0xFFFFFFFF. lbu at 0x13 → 0x00000080. lh at 0x12 → 0xFFFF80FF. Each has rsp_valid 3 cycles after accept.
- sb 0xAB at 0x11 onto 0x11223344 → mem_wdata=0x1122AB44 in the WRITE cycle, mem_we high for exactly 1 cycle, rsp_valid 4 cycles after accept.
- With LSA_MISALIGN_TRAP_EN, lw at 0x06 → rsp_err=1 after 1 cycle, mem_en never asserted. Without the macro → reads word 0x04.
- DATA_W=32, size 3 → rsp_err=1. DATA_W=64, ld at 0x08 → full 64-bit word returned.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready stays 0 throughout.
- Assert reset in the CAPT cycle of an sh → mem_we never rises, and all outputs go to their reset values.

Source files
------------

// File: rtl/lsa_pkg.sv
// Shared types for the load/store alignment unit: size codes, FSM states,
// latched request control fields and the access byte-count helper.
package lsa_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_e;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
    } req_ctrl_t;

    // Number of bytes touched by an access of the given size code.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/load_store_align_if.sv
// Request/response and memory-side bus of the load/store alignment unit.
interface load_store_align_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) ();
    localparam int unsigned LG = $clog2(DATA_W / 8);

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_W-LG-1:0] mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_W-1:0]    rsp_rdata;
    logic                 rsp_err;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata, rsp_ready,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata, rsp_ready,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/load_extend.sv
// Selects the lane at the byte offset and sign- or zero-extends it to DATA_W.
module load_extend
    import lsa_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]            word_i,
    input  logic [$clog2(DATA_W/8)-1:0]  off_i,
    input  logic [1:0]                   size_i,
    input  logic                         unsigned_i,
    output logic [DATA_W-1:0]            data_o
);
    localparam int unsigned IW = $clog2(DATA_W);

    logic [DATA_W-1:0] shifted;
    int unsigned       nbits;
    int unsigned       raw_bits;
    logic              sign;

    // Bits above the selected lane take the lane MSB unless zero-extending.
    always_comb begin
        shifted  = word_i >> {off_i, 3'b000};
        raw_bits = 32'(size_bytes(size_i)) * 32'd8;
        nbits    = (raw_bits > DATA_W) ? DATA_W : raw_bits;
        sign     = shifted[IW'(nbits - 32'd1)] & ~unsigned_i;
        data_o   = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            data_o[i] = (i < nbits) ? shifted[i] : sign;
        end
    end

endmodule

// File: rtl/load_store_align.sv
// Handshaked load/store alignment unit: sub-word loads with extension and
// read-modify-write sub-word stores. LSA_MISALIGN_TRAP_EN turns misaligned
// accesses into errors instead of aligning them down.
module load_store_align
    import lsa_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    load_store_align_if.slave   bus
);
    localparam int unsigned LG  = $clog2(DATA_W / 8);
    localparam int unsigned NB  = DATA_W / 8;
    localparam logic [3:0]  NB4 = 4'(NB);

    state_e               state_q;
    req_ctrl_t            ctrl_q;
    logic [LG-1:0]        off_q;
    logic [DATA_W-1:0]    wdata_q;

    logic                 req_ready_q;
    logic                 mem_en_q;
    logic                 mem_we_q;
    logic [ADDR_W-LG-1:0] mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic                 rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;
    logic                 rsp_err_q;

    logic [LG-1:0]        req_off;
    logic [LG-1:0]        req_mask;
    logic [LG-1:0]        req_off_al;
    logic [3:0]           req_nb;
    logic                 req_full;
    logic                 req_err;

    logic [DATA_W-1:0]    load_ext;
    logic [DATA_W-1:0]    merge_d;
    logic [DATA_W-1:0]    wshift;
    logic [3:0]           st_nb;
    logic                 lane;

    assign bus.req_ready = req_ready_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Request decode: size legality, alignment and effective lane offset.
    always_comb begin
        req_off  = bus.req_addr[LG-1:0];
        req_nb   = size_bytes(bus.req_size);
        req_mask = LG'(req_nb - 4'd1);
        req_full = (req_nb == NB4);
`ifdef LSA_MISALIGN_TRAP_EN
        req_err    = (req_nb > NB4) || ((req_off & req_mask) != '0);
        req_off_al = req_off;
`else
        req_err    = (req_nb > NB4);
        req_off_al = req_off & ~req_mask;
`endif
    end

    load_extend #(.DATA_W(DATA_W)) u_extend (
        .word_i     (bus.mem_rdata),
        .off_i      (off_q),
        .size_i     (ctrl_q.size),
        .unsigned_i (ctrl_q.uns),
        .data_o     (load_ext)
    );

    // Store merge: new bytes only in the addressed lanes, the rest from memory.
    always_comb begin
        wshift  = wdata_q << {off_q, 3'b000};
        st_nb   = size_bytes(ctrl_q.size);
        lane    = 1'b0;
        merge_d = bus.mem_rdata;
        for (int unsigned k = 0; k < NB; k++) begin
            lane = (k >= 32'(off_q)) && (k < 32'(off_q) + 32'(st_nb));
            merge_d[8*k +: 8] = lane ? wshift[8*k +: 8] : bus.mem_rdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        ctrl_q      <= '{we: bus.req_we, size: bus.req_size, uns: bus.req_unsigned};
                        off_q       <= req_off_al;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= req_err;
                        if (req_err) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            mem_addr_q <= bus.req_addr[ADDR_W-1:LG];
                            mem_en_q   <= 1'b1;
                            if (bus.req_we && req_full) begin
                                state_q     <= WRITE;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= bus.req_wdata;
                            end else begin
                                state_q <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    state_q <= CAPT;
                end
                CAPT: begin
                    if (ctrl_q.we) begin
                        state_q     <= WRITE;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merge_d;
                    end else begin
                        state_q     <= RESP;
                        rsp_rdata_q <= load_ext;
                        rsp_valid_q <= 1'b1;
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_align.sv
// Directed bench for load_store_align with 32-bit and 64-bit instances.
module tb_load_store_align;
    import lsa_pkg::*;

    logic clk;
    logic reset;
    logic mem_init;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    load_store_align_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
    load_store_align_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

    load_store_align #(.DATA_W(32), .ADDR_W(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    load_store_align #(.DATA_W(64), .ADDR_W(32)) dut64 (.clk(clk), .reset(reset), .bus(b64));

    logic [31:0] mem32 [0:63];
    logic [63:0] mem64 [0:15];

    // Synchronous memories: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem32[i] <= 32'h0;
            for (int i = 0; i < 16; i++) mem64[i] <= 64'h0;
            mem32[4] <= 32'h80FF7F01;
            mem32[1] <= 32'hCAFEBABE;
            mem64[1] <= 64'h0123456789ABCDEF;
        end else begin
            if (b32.mem_en) begin
                if (b32.mem_we) mem32[b32.mem_addr[5:0]] <= b32.mem_wdata;
                else            b32.mem_rdata <= mem32[b32.mem_addr[5:0]];
            end
            if (b64.mem_en) begin
                if (b64.mem_we) mem64[b64.mem_addr[3:0]] <= b64.mem_wdata;
                else            b64.mem_rdata <= mem64[b64.mem_addr[3:0]];
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    int          lat, en_cnt, we_cnt;
    logic [31:0] rd, wd;
    logic [63:0] rd64;
    logic        er;

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        b32.req_valid = 1'b1; b32.req_we = we; b32.req_size = sz;
        b32.req_unsigned = uns; b32.req_addr = addr; b32.req_wdata = wdata;
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
        lat = 1; en_cnt = 0; we_cnt = 0; wd = '0;
        while (!b32.rsp_valid && lat < 20) begin
            if (b32.mem_en) en_cnt++;
            if (b32.mem_we) begin we_cnt++; wd = b32.mem_wdata; end
            @(posedge clk); #1;
            lat++;
        end
        rd = b32.rsp_rdata; er = b32.rsp_err;
        if (b32.rsp_ready) begin @(posedge clk); #1; end
    endtask

    task automatic do_req64(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [63:0] wdata);
        @(negedge clk);
        b64.req_valid = 1'b1; b64.req_we = we; b64.req_size = sz;
        b64.req_unsigned = uns; b64.req_addr = addr; b64.req_wdata = wdata;
        @(posedge clk); #1;
        b64.req_valid = 1'b0;
        lat = 1; en_cnt = 0;
        while (!b64.rsp_valid && lat < 20) begin
            if (b64.mem_en) en_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        rd64 = b64.rsp_rdata; er = b64.rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++; if (b32.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", b32.req_ready); end
        n_chk++; if (b32.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", b32.rsp_valid); end
        n_chk++; if (b32.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", b32.rsp_rdata); end
        n_chk++; if (b32.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", b32.rsp_err); end
        n_chk++; if (b32.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b want 0", b32.mem_en); end
        n_chk++; if (b32.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", b32.mem_we); end
        n_chk++; if (b32.mem_addr !== 30'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", b32.mem_addr); end
        n_chk++; if (b32.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", b32.mem_wdata); end
    endtask

    task automatic test_loads();
        logic [1:0]  t_sz  [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1};
        logic        t_uns [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_adr [9] = '{32'h12, 32'h13, 32'h12, 32'h12, 32'h11, 32'h10, 32'h10, 32'h10, 32'h10};
        logic [31:0] t_exp [9] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F,
                                   32'h00000001, 32'h80FF7F01, 32'h80FF7F01, 32'h00007F01};
        for (int i = 0; i < 9; i++) begin
            do_req(1'b0, t_sz[i], t_uns[i], t_adr[i], 32'h0);
            n_chk++; if (rd !== t_exp[i]) begin n_fail++; $display("FAIL load[%0d] rdata got %h want %h", i, rd, t_exp[i]); end
            n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL load[%0d] latency got %0d want 3", i, lat); end
            n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL load[%0d] err got %b want 0", i, er); end
            n_chk++; if (en_cnt !== 1) begin n_fail++; $display("FAIL load[%0d] mem_en cycles got %0d want 1", i, en_cnt); end
        end
    endtask

    task automatic test_store_full();
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL sw latency got %0d want 2", lat); end
        n_chk++; if (we_cnt !== 1) begin n_fail++; $display("FAIL sw mem_we cycles got %0d want 1", we_cnt); end
        n_chk++; if (en_cnt !== 1) begin n_fail++; $display("FAIL sw mem_en cycles got %0d want 1", en_cnt); end
        n_chk++; if (wd !== 32'h11223344) begin n_fail++; $display("FAIL sw mem_wdata got %h want 11223344", wd); end
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw rsp_rdata got %h want 0", rd); end
        n_chk++; if (mem32[4] !== 32'h11223344) begin n_fail++; $display("FAIL sw memory got %h want 11223344", mem32[4]); end
    endtask

    task automatic test_store_sub();
        logic [1:0]  t_sz  [3] = '{2'd0, 2'd1, 2'd0};
        logic [31:0] t_adr [3] = '{32'h11, 32'h12, 32'h13};
        logic [31:0] t_wd  [3] = '{32'h000000AB, 32'h0000BEEF, 32'h123456CD};
        logic [31:0] t_exp [3] = '{32'h1122AB44, 32'hBEEFAB44, 32'hCDEFAB44};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, t_sz[i], 1'b0, t_adr[i], t_wd[i]);
            n_chk++; if (wd !== t_exp[i]) begin n_fail++; $display("FAIL sub_store[%0d] mem_wdata got %h want %h", i, wd, t_exp[i]); end
            n_chk++; if (we_cnt !== 1) begin n_fail++; $display("FAIL sub_store[%0d] mem_we cycles got %0d want 1", i, we_cnt); end
            n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL sub_store[%0d] latency got %0d want 4", i, lat); end
            n_chk++; if (mem32[4] !== t_exp[i]) begin n_fail++; $display("FAIL sub_store[%0d] memory got %h want %h", i, mem32[4], t_exp[i]); end
        end
    endtask

    task automatic test_misalign();
        do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
`ifdef LSA_MISALIGN_TRAP_EN
        n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL lw_0x06 err got %b want 1", er); end
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL lw_0x06 latency got %0d want 1", lat); end
        n_chk++; if (en_cnt !== 0) begin n_fail++; $display("FAIL lw_0x06 mem_en cycles got %0d want 0", en_cnt); end
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL lw_0x06 rdata got %h want 0", rd); end
`else
        n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_0x06 err got %b want 0", er); end
        n_chk++; if (rd !== 32'hCAFEBABE) begin n_fail++; $display("FAIL lw_0x06 rdata got %h want cafebabe", rd); end
        n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL lw_0x06 latency got %0d want 3", lat); end
`endif
        do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
`ifdef LSA_MISALIGN_TRAP_EN
        n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL lh_0x13 err got %b want 1", er); end
`else
        n_chk++; if (rd !== 32'hFFFFCDEF) begin n_fail++; $display("FAIL lh_0x13 rdata got %h want ffffcdef", rd); end
`endif
    endtask

    task automatic test_illegal_size();
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL ld32 err got %b want 1", er); end
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ld32 rdata got %h want 0", rd); end
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL ld32 latency got %0d want 1", lat); end
        n_chk++; if (en_cnt !== 0) begin n_fail++; $display("FAIL ld32 mem_en cycles got %0d want 0", en_cnt); end
        do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'hDEADBEEF);
        n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL sd32 err got %b want 1", er); end
        n_chk++; if (we_cnt !== 0) begin n_fail++; $display("FAIL sd32 mem_we cycles got %0d want 0", we_cnt); end
        n_chk++; if (mem32[4] !== 32'hCDEFAB44) begin n_fail++; $display("FAIL sd32 memory got %h want cdefab44", mem32[4]); end
    endtask

    task automatic test_dword64();
        logic [1:0]  t_sz  [4] = '{2'd3, 2'd2, 2'd2, 2'd0};
        logic        t_uns [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_adr [4] = '{32'h08, 32'h08, 32'h0C, 32'h09};
        logic [63:0] t_exp [4] = '{64'h0123456789ABCDEF, 64'hFFFFFFFF89ABCDEF,
                                   64'h0000000001234567, 64'hFFFFFFFFFFFFFFCD};
        for (int i = 0; i < 4; i++) begin
            do_req64(1'b0, t_sz[i], t_uns[i], t_adr[i], 64'h0);
            n_chk++; if (rd64 !== t_exp[i]) begin n_fail++; $display("FAIL load64[%0d] rdata got %h want %h", i, rd64, t_exp[i]); end
            n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL load64[%0d] latency got %0d want 3", i, lat); end
        end
        do_req64(1'b1, 2'd3, 1'b0, 32'h10, 64'hA5A5A5A55A5A5A5A);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL sd64 latency got %0d want 2", lat); end
        n_chk++; if (mem64[2] !== 64'hA5A5A5A55A5A5A5A) begin n_fail++; $display("FAIL sd64 memory got %h want a5a5a5a55a5a5a5a", mem64[2]); end
    endtask

    task automatic test_hold();
        b32.rsp_ready = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        n_chk++; if (rd !== 32'hCDEFAB44) begin n_fail++; $display("FAIL hold rdata got %h want cdefab44", rd); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_chk++; if (b32.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold[%0d] rsp_valid got %b want 1", i, b32.rsp_valid); end
            n_chk++; if (b32.rsp_rdata !== 32'hCDEFAB44) begin n_fail++; $display("FAIL hold[%0d] rsp_rdata got %h want cdefab44", i, b32.rsp_rdata); end
            n_chk++; if (b32.req_ready !== 1'b0) begin n_fail++; $display("FAIL hold[%0d] req_ready got %b want 0", i, b32.req_ready); end
        end
        b32.rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (b32.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_retire rsp_valid got %b want 0", b32.rsp_valid); end
        n_chk++; if (b32.req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_retire req_ready got %b want 1", b32.req_ready); end
    endtask

    task automatic test_reset_mid();
        int we_seen;
        we_seen = 0;
        @(negedge clk);
        b32.req_valid = 1'b1; b32.req_we = 1'b1; b32.req_size = 2'd1;
        b32.req_unsigned = 1'b0; b32.req_addr = 32'h12; b32.req_wdata = 32'h00007777;
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_chk++; if (b32.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst req_ready got %b want 1", b32.req_ready); end
        n_chk++; if (b32.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst rsp_valid got %b want 0", b32.rsp_valid); end
        n_chk++; if (b32.rsp_err !== 1'b0) begin n_fail++; $display("FAIL midrst rsp_err got %b want 0", b32.rsp_err); end
        n_chk++; if (b32.mem_en !== 1'b0) begin n_fail++; $display("FAIL midrst mem_en got %b want 0", b32.mem_en); end
        n_chk++; if (b32.mem_addr !== 30'h0) begin n_fail++; $display("FAIL midrst mem_addr got %h want 0", b32.mem_addr); end
        n_chk++; if (b32.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL midrst mem_wdata got %h want 0", b32.mem_wdata); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (b32.mem_we) we_seen++;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (b32.mem_we) we_seen++;
        end
        n_chk++; if (we_seen !== 0) begin n_fail++; $display("FAIL midrst mem_we cycles got %0d want 0", we_seen); end
        n_chk++; if (mem32[4] !== 32'hCDEFAB44) begin n_fail++; $display("FAIL midrst memory got %h want cdefab44", mem32[4]); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        n_chk++; if (rd !== 32'hCDEFAB44) begin n_fail++; $display("FAIL post_rst lw rdata got %h want cdefab44", rd); end
    endtask

    initial begin
        reset = 1'b1;
        mem_init = 1'b1;
        b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_size = 2'd0; b32.req_unsigned = 1'b0;
        b32.req_addr = '0; b32.req_wdata = '0; b32.rsp_ready = 1'b1;
        b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_size = 2'd0; b64.req_unsigned = 1'b0;
        b64.req_addr = '0; b64.req_wdata = '0; b64.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        reset = 1'b0;
        mem_init = 1'b0;
        repeat (2) @(posedge clk);
        test_loads();
        test_store_full();
        test_store_sub();
        test_misalign();
        test_illegal_size();
        test_dword64();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
